// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and divider timing for the MDU HI/LO control unit.
package mdu_pkg;

  // Number of cycles the iterative divider holds div_busy high.
  localparam int unsigned DIV_CYCLES = 32;

  // MDU op encoding driven by decode into EX.
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;
  localparam logic [2:0] OP_MFHI = 3'd5;
  localparam logic [2:0] OP_MFLO = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_hilo_ctrl_hilo_regs.sv
// Architectural HI/LO storage with independent write enables and a read mux.
module hilo_regs
  import mdu_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_hi,
  input  logic          we_lo,
  input  logic [DW-1:0] wd_hi,
  input  logic [DW-1:0] wd_lo,
  input  logic          rd_hi,
  input  logic          rd_lo,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo,
  output logic [DW-1:0] rd_data
);

  // HI/LO update; reset wins over any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (we_hi) hi <= wd_hi;
      if (we_lo) lo <= wd_lo;
    end
  end

  // MFHI/MFLO read path; zero for any other op.
  always_comb begin
    rd_data = '0;
    if (rd_hi)      rd_data = hi;
    else if (rd_lo) rd_data = lo;
  end

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// EX-stage multiply/divide control: divider handshake, pipeline stall, HI/LO ownership.
// Optional feature macro: MDU_DIVZERO_EN (zero divisor skips the divider, adds divzero port).
module mdu_hilo_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned OPW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            ex_stall_in,
  input  logic            op_valid,
  input  logic [OPW-1:0]  op,
  input  logic [DW-1:0]   rs_val,
  input  logic [DW-1:0]   rt_val,
  input  logic            div_busy,
  input  logic [2*DW-1:0] div_out,
  output logic            div_en,
  output logic            div_ready,
  output logic            div_flush,
  output logic [DW-1:0]   div_a,
  output logic [DW-1:0]   div_b,
  output logic            div_unsign,
  output logic            mdu_stall,
  output logic [DW-1:0]   mf_data,
  output logic [DW-1:0]   hi,
`ifdef MDU_DIVZERO_EN
  output logic [DW-1:0]   lo,
  output logic            divzero
`else
  output logic [DW-1:0]   lo
`endif
);

  state_t state;
  logic   busy_seen;

  logic op_div, op_divu, op_mthi, op_mtlo, op_mfhi, op_mflo;
  logic is_div, rt_zero, capture, mt_ok;
  logic we_hi, we_lo;
  logic [DW-1:0] wd_hi, wd_lo;

  // Op decode.
  assign op_div  = (op == OPW'(OP_DIV));
  assign op_divu = (op == OPW'(OP_DIVU));
  assign op_mthi = (op == OPW'(OP_MTHI));
  assign op_mtlo = (op == OPW'(OP_MTLO));
  assign op_mfhi = (op == OPW'(OP_MFHI));
  assign op_mflo = (op == OPW'(OP_MFLO));
  assign is_div  = op_valid & (op_div | op_divu);

`ifdef MDU_DIVZERO_EN
  assign rt_zero = (rt_val == '0);
`else
  assign rt_zero = 1'b0;
`endif

  // Divider handshake and hazard stall; operands are held stable by the EX stage.
  assign div_a      = rs_val;
  assign div_b      = rt_val;
  assign div_unsign = op_divu;
  assign div_flush  = flush | rst;
  assign div_en     = is_div & ((state != IDLE) | ~flush) & ~rt_zero;
  assign div_ready  = ((state == WAIT) & ~div_busy) | (state == DONE);
  assign mdu_stall  = is_div & (state != DONE) & ~flush;

  // Result capture only after the divider has been seen busy, so the launch cycle cannot fake a finish.
  assign capture = (state == WAIT) & busy_seen & ~div_busy & ~flush;
  assign mt_ok   = (state == IDLE) & op_valid & ~flush & ~ex_stall_in;

  assign we_hi = capture | (mt_ok & op_mthi);
  assign we_lo = capture | (mt_ok & op_mtlo);
  assign wd_hi = capture ? div_out[2*DW-1:DW] : rs_val;
  assign wd_lo = capture ? div_out[DW-1:0]    : rs_val;

  // Control FSM: launch, wait for the divider, hold the result until EX releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy_seen <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      busy_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_div) begin
            busy_seen <= 1'b0;
            state     <= rt_zero ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (div_busy) busy_seen <= 1'b1;
          if (capture) begin
            busy_seen <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (!ex_stall_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MDU_DIVZERO_EN
  // One-cycle pulse in the DONE cycle entered straight from a zero-divisor launch.
  always_ff @(posedge clk) begin
    if (rst) divzero <= 1'b0;
    else     divzero <= ~flush & (state == IDLE) & is_div & rt_zero;
  end
`endif

  hilo_regs #(.DW(DW)) u_hilo_regs (
    .clk     (clk),
    .rst     (rst),
    .we_hi   (we_hi),
    .we_lo   (we_lo),
    .wd_hi   (wd_hi),
    .wd_lo   (wd_lo),
    .rd_hi   (op_mfhi),
    .rd_lo   (op_mflo),
    .hi      (hi),
    .lo      (lo),
    .rd_data (mf_data)
  );

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Testbench for mdu_hilo_ctrl: behavioural 32-cycle divider, table of ops with a scoreboard,
// plus hand sequences for flush, held DONE, reset mid-divide and zero divisor.
module tb_mdu_hilo_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, ex_stall_in, op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        div_busy = 1'b0;
  logic [63:0] div_out = '0;
  logic        div_en, div_ready, div_flush, div_unsign, mdu_stall;
  logic [31:0] div_a, div_b, mf_data, hi, lo;
`ifdef MDU_DIVZERO_EN
  logic        divzero;
`endif

  mdu_hilo_ctrl #(.DW(32), .OPW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .ex_stall_in(ex_stall_in),
    .op_valid   (op_valid),
    .op         (op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .div_busy   (div_busy),
    .div_out    (div_out),
    .div_en     (div_en),
    .div_ready  (div_ready),
    .div_flush  (div_flush),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_unsign (div_unsign),
    .mdu_stall  (mdu_stall),
    .mf_data    (mf_data),
    .hi         (hi),
`ifdef MDU_DIVZERO_EN
    .divzero    (divzero),
`endif
    .lo         (lo)
  );

  always #5 clk = ~clk;

  // ---------------- divider model ----------------
  int cnt = 0;
  int starts = 0;

  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b, input logic u);
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (u) begin
      q = a / b;
      r = a % b;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
    return {r, q};
  endfunction

  always @(posedge clk) begin
    if (div_flush) begin
      div_busy <= 1'b0;
      cnt      <= 0;
    end else if (div_busy) begin
      if (cnt == 1) div_busy <= 1'b0;
      cnt <= cnt - 1;
    end else if (div_en && !div_ready) begin
      div_busy <= 1'b1;
      cnt      <= DIV_CYCLES;
      div_out  <= div_model(div_a, div_b, div_unsign);
      starts   <= starts + 1;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic [31:0] exp_mf;
  } vec_t;

  vec_t tbl[12];
  vec_t sb[$];

  function automatic bit is_div_op(input logic [2:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic bit launches(input vec_t v);
`ifdef MDU_DIVZERO_EN
    return is_div_op(v.op) && (v.rt != 32'd0);
`else
    return is_div_op(v.op);
`endif
  endfunction

  function automatic int exp_stall(input vec_t v);
    if (!is_div_op(v.op)) return 0;
    return launches(v) ? (DIV_CYCLES + 2) : 1;
  endfunction

  // Issue one op from IDLE at posedge+1, run it to completion, compare against the scoreboard.
  task automatic run_op(input vec_t v);
    vec_t        e;
    int          stall;
    int          starts0;
    bit          done;
    logic [31:0] mf;
    starts0  = starts;
    op_valid = 1'b1;
    op       = v.op;
    rs_val   = v.rs;
    rt_val   = v.rt;
    sb.push_back(v);
    stall = 0;
    done  = 1'b0;
    mf    = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) mf = mf_data;
      if (!mdu_stall) begin
        done = 1'b1;
        break;
      end
      stall++;
    end
    check("op_completes", 64'(done), 64'd1);
    check("div_ready_at_release", 64'(div_ready), 64'(is_div_op(v.op)));
    @(posedge clk); #1;
    op_valid = 1'b0;
    op       = OP_NONE;
    @(negedge clk);
    e = sb.pop_front();
    check("stall_cycles", 64'(stall), 64'(exp_stall(e)));
    check("hi", 64'(hi), 64'(e.exp_hi));
    check("lo", 64'(lo), 64'(e.exp_lo));
    check("mf_data", 64'(mf), 64'(e.exp_mf));
    check("divider_starts", 64'(starts - starts0), 64'(launches(e)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          starts0;
    int          stall;
    bit          done;
    logic [31:0] h0, l0;

    //                 op       rs            rt     exp_hi        exp_lo        exp_mf
    tbl[0]  = '{OP_MTHI, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'h0000_0000, 32'h0};
    tbl[1]  = '{OP_MFHI, 32'h0,         32'd0, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234};
    tbl[2]  = '{OP_MTLO, 32'h0000_CAFE, 32'd0, 32'h0000_1234, 32'h0000_CAFE, 32'h0};
    tbl[3]  = '{OP_MFLO, 32'h0,         32'd0, 32'h0000_1234, 32'h0000_CAFE, 32'h0000_CAFE};
    tbl[4]  = '{OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0};
    tbl[5]  = '{OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 32'h0};
    tbl[6]  = '{OP_MFHI, 32'h0,         32'd0, 32'h0000_0001, 32'h7FFF_FFFC, 32'h0000_0001};
    tbl[7]  = '{OP_DIV,  32'd100,       32'd7, 32'h0000_0002, 32'h0000_000E, 32'h0};
    tbl[8]  = '{OP_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 32'h0};
    tbl[9]  = '{OP_NONE, 32'd123,       32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 32'h0};
`ifdef MDU_DIVZERO_EN
    tbl[10] = '{OP_DIV,  32'd5,         32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 32'h0};
    tbl[11] = '{OP_MFLO, 32'h0,         32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 32'hFFFF_FFF2};
`else
    tbl[10] = '{OP_DIV,  32'd5,         32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0};
    tbl[11] = '{OP_MFLO, 32'h0,         32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
`endif

    // Reset
    rst = 1'b1; flush = 1'b0; ex_stall_in = 1'b0; op_valid = 1'b0;
    op = OP_NONE; rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_stall", 64'(mdu_stall), 64'd0);
    check("rst_div_en", 64'(div_en), 64'd0);
    check("rst_div_ready", 64'(div_ready), 64'd0);
    check("rst_div_flush", 64'(div_flush), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_div_flush", 64'(div_flush), 64'd0);
    check("post_rst_mf", 64'(mf_data), 64'd0);
`ifdef MDU_DIVZERO_EN
    check("post_rst_divzero", 64'(divzero), 64'd0);
`endif
    @(posedge clk); #1;

    // Table-driven ops
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i]);
      @(posedge clk); #1;
    end
    h0 = tbl[11].exp_hi;
    l0 = tbl[11].exp_lo;

    // Flush in cycle 10 of a DIV
    starts0 = starts;
    op_valid = 1'b1; op = OP_DIV; rs_val = 32'd50; rt_val = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_div_flush", 64'(div_flush), 64'd1);
    check("flush_stall", 64'(mdu_stall), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0; op = OP_NONE;
    @(negedge clk);
    check("flush_idle_ready", 64'(div_ready), 64'd0);
    check("flush_idle_stall", 64'(mdu_stall), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_hi_kept", 64'(hi), 64'(h0));
    check("flush_lo_kept", 64'(lo), 64'(l0));
    check("flush_starts", 64'(starts - starts0), 64'd1);
    @(posedge clk); #1;

    // DIV completes while EX is held: stays in DONE, no restart
    starts0 = starts;
    ex_stall_in = 1'b1;
    op_valid = 1'b1; op = OP_DIV; rs_val = 32'd9; rt_val = 32'd4;
    stall = 0; done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!mdu_stall) begin
        done = 1'b1;
        break;
      end
      stall++;
    end
    check("held_completes", 64'(done), 64'd1);
    check("held_stall_cycles", 64'(stall), 64'(DIV_CYCLES + 2));
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("held_stall", 64'(mdu_stall), 64'd0);
      check("held_div_en", 64'(div_en), 64'd1);
      check("held_div_ready", 64'(div_ready), 64'd1);
      check("held_hi", 64'(hi), 64'd1);
      check("held_lo", 64'(lo), 64'd2);
    end
    @(posedge clk); #1;
    ex_stall_in = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NONE;
    @(negedge clk);
    check("held_idle_ready", 64'(div_ready), 64'd0);
    check("held_starts", 64'(starts - starts0), 64'd1);
    check("held_hi_final", 64'(hi), 64'd1);
    check("held_lo_final", 64'(lo), 64'd2);
    @(posedge clk); #1;

    // Reset mid-divide clears HI/LO and aborts
    op_valid = 1'b1; op = OP_DIV; rs_val = 32'd20; rt_val = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_div_flush", 64'(div_flush), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0; op_valid = 1'b0; op = OP_NONE;
    @(negedge clk);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    check("rst_mid_stall", 64'(mdu_stall), 64'd0);
    check("rst_mid_ready", 64'(div_ready), 64'd0);
    @(posedge clk); #1;

    // MTHI right after reset recovery: proves IDLE and leaves LO alone
    run_op('{OP_MTHI, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'h0, 32'h0});
    @(posedge clk); #1;
    run_op('{OP_MFHI, 32'h0, 32'd0, 32'h0000_1234, 32'h0, 32'h0000_1234});
    @(posedge clk); #1;

`ifdef MDU_DIVZERO_EN
    // Zero divisor: one stall cycle, divzero pulse, divider never enabled
    starts0 = starts;
    op_valid = 1'b1; op = OP_DIV; rs_val = 32'd7; rt_val = 32'd0;
    @(negedge clk);
    check("dz_c0_div_en", 64'(div_en), 64'd0);
    check("dz_c0_stall", 64'(mdu_stall), 64'd1);
    check("dz_c0_pulse", 64'(divzero), 64'd0);
    @(negedge clk);
    check("dz_c1_div_en", 64'(div_en), 64'd0);
    check("dz_c1_stall", 64'(mdu_stall), 64'd0);
    check("dz_c1_pulse", 64'(divzero), 64'd1);
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NONE;
    @(negedge clk);
    check("dz_pulse_end", 64'(divzero), 64'd0);
    check("dz_hi", 64'(hi), 64'h1234);
    check("dz_lo", 64'(lo), 64'd0);
    check("dz_starts", 64'(starts - starts0), 64'd0);
`endif

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
